// File: rtl/uart_hex_printer.sv
// Prints a latched 32-bit word as "0x" + DIGITS hex chars + CR LF into the UART TX FIFO.
// Each byte takes 2 cycles (SEND + GAP); waits in SEND while tx_ready is low; tx_start/tx_data are registered.
module uart_hex_printer #(
  parameter int unsigned DIGITS    = 8,
  parameter bit          UPPERCASE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        tx_overflow
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  localparam logic [3:0] LAST_IDX = 4'(DIGITS + 3);
  localparam logic [3:0] TOP_NIB  = 4'(DIGITS + 1);

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [31:0] value_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        tx_start_q;
  logic [7:0]  tx_data_q;

  logic [2:0]  nib_sel_d;
  logic [3:0]  nib_d;
  logic [7:0]  byte_d;

  // Hex chars occupy byte indices 2..DIGITS+1, mapping to nibbles DIGITS-1..0.
  assign nib_sel_d = 3'(TOP_NIB - idx_q);
  assign nib_d     = value_q[{nib_sel_d, 2'b00} +: 4];

  always_comb begin
    byte_d = 8'h00;
    if (idx_q == 4'd0) begin
      byte_d = 8'h30;
    end else if (idx_q == 4'd1) begin
      byte_d = 8'h78;
    end else if (idx_q == LAST_IDX - 4'd1) begin
      byte_d = 8'h0D;
    end else if (idx_q == LAST_IDX) begin
      byte_d = 8'h0A;
    end else if (nib_d < 4'd10) begin
      byte_d = 8'h30 + {4'h0, nib_d};
    end else begin
      byte_d = (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, nib_d} - 8'd10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      value_q    <= 32'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      if (busy_q && tx_overflow) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            value_q <= value;
            err_q   <= 1'b0;
            idx_q   <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= byte_d;
            state_q    <= GAP;
          end
        end
        GAP: begin
          // tx_ready lags by a cycle, so it is only trusted again after this gap.
          if (idx_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            idx_q   <= idx_q + 4'd1;
            state_q <= SEND;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_hex_printer.sv
// Bench for uart_hex_printer: two instances (8 digits upper-case, 2 digits lower-case) against a string model.
module tb_uart_hex_printer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_ready = 1'b1;
  logic        tx_ovf = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] value_a = 32'h0, value_b = 32'h0;
  logic        busy_a, done_a, err_a, txs_a;
  logic        busy_b, done_b, err_b, txs_b;
  logic [7:0]  txd_a, txd_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0] bytes_a[$];
  int         times_a[$];
  int         done_a_cnt = 0, done_a_cyc = 0;
  int         consec_a = 0, hold_a = 0;
  logic       prev_txs_a = 1'b0;
  logic [7:0] prev_txd_a = 8'h00;
  logic [7:0] bytes_b[$];
  int         done_b_cnt = 0;
  logic [7:0] exp_q[$];

  uart_hex_printer #(.DIGITS(8), .UPPERCASE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .value(value_a),
    .busy(busy_a), .done(done_a), .err(err_a),
    .tx_start(txs_a), .tx_data(txd_a), .tx_ready(tx_ready), .tx_overflow(tx_ovf)
  );

  uart_hex_printer #(.DIGITS(2), .UPPERCASE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .value(value_b),
    .busy(busy_b), .done(done_b), .err(err_b),
    .tx_start(txs_b), .tx_data(txd_b), .tx_ready(tx_ready), .tx_overflow(tx_ovf)
  );

  always #5 clk = ~clk;

  // Observe outputs shortly after each rising edge; cyc numbers the cycle just begun.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (txs_a === 1'b1) begin
      bytes_a.push_back(txd_a);
      times_a.push_back(cyc);
      if (prev_txs_a === 1'b1) consec_a++;
    end else if (rst === 1'b0 && txd_a !== prev_txd_a) begin
      hold_a++;
    end
    if (done_a === 1'b1) begin
      done_a_cnt++;
      done_a_cyc = cyc;
    end
    prev_txs_a = txs_a;
    prev_txd_a = txd_a;
    if (txs_b === 1'b1) bytes_b.push_back(txd_b);
    if (done_b === 1'b1) done_b_cnt++;
  end

  // Expected string: "0x", then d hex digits most-significant first, then CR LF.
  function automatic void build_exp(input logic [31:0] v, input int d, input bit up);
    int n;
    exp_q.delete();
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h78);
    for (int k = d - 1; k >= 0; k--) begin
      n = int'((v >> (4 * k)) & 32'hF);
      if (n < 10) exp_q.push_back(8'(48 + n));
      else        exp_q.push_back(8'((up ? 65 : 97) + n - 10));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic clear_a();
    bytes_a.delete();
    times_a.delete();
    done_a_cnt = 0;
  endtask

  task automatic start_pulse_a(input logic [31:0] v);
    @(negedge clk);
    start_a = 1'b1;
    value_a = v;
    @(negedge clk);
    start_a = 1'b0;
    value_a = $urandom;
  endtask

  task automatic wait_done_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_strobes_a(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bytes_a.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy_a got %b want 0", busy_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done_a got %b want 0", done_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL reset_err_a got %b want 0", err_a); end
    n_cmp++; if (txs_a !== 1'b0) begin n_bad++; $display("FAIL reset_txs_a got %b want 0", txs_a); end
    n_cmp++; if (txd_a !== 8'h00) begin n_bad++; $display("FAIL reset_txd_a got %h want 00", txd_a); end
    n_cmp++; if (busy_b !== 1'b0 || txs_b !== 1'b0) begin n_bad++; $display("FAIL reset_b got busy=%b txs=%b want 0 0", busy_b, txs_b); end
    rst = 1'b0;
    @(negedge clk);
    tx_ovf = 1'b1;
    @(negedge clk);
    tx_ovf = 1'b0;
    @(negedge clk);
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL idle_ovf_err got %b want 0", err_a); end
  endtask

  task automatic check_string_a(input logic [31:0] v, input bit timing);
    bit ok;
    clear_a();
    start_pulse_a(v);
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL str_busy v=%h got %b want 1", v, busy_a); end
    wait_done_a(200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL str_done_timeout v=%h got no done want done", v); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL str_busy_at_done v=%h got %b want 0", v, busy_a); end
    build_exp(v, 8, 1'b1);
    n_cmp++;
    if (bytes_a.size() != exp_q.size()) begin
      n_bad++; $display("FAIL str_len v=%h got %0d want %0d", v, bytes_a.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (bytes_a[i] !== exp_q[i]) begin n_bad++; $display("FAIL str_byte v=%h idx=%0d got %h want %h", v, i, bytes_a[i], exp_q[i]); end
      end
      if (timing) begin
        for (int i = 1; i < times_a.size(); i++) begin
          n_cmp++;
          if (times_a[i] - times_a[i-1] != 2) begin n_bad++; $display("FAIL str_gap idx=%0d got %0d want 2", i, times_a[i] - times_a[i-1]); end
        end
        n_cmp++;
        if (done_a_cyc != times_a[times_a.size()-1] + 1) begin
          n_bad++; $display("FAIL str_done_time got %0d want %0d", done_a_cyc, times_a[times_a.size()-1] + 1);
        end
      end
    end
    @(negedge clk);
    n_cmp++; if (done_a !== 1'b0 || done_a_cnt != 1) begin n_bad++; $display("FAIL str_done_once got done=%b cnt=%0d want 0 1", done_a, done_a_cnt); end
  endtask

  task automatic test_beef();
    check_string_a(32'h0000BEEF, 1'b1);
  endtask

  task automatic test_random_a();
    for (int k = 0; k < 4; k++) check_string_a($urandom, 1'b1);
  endtask

  task automatic test_digits2();
    logic [31:0] v;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      v = (k == 0) ? 32'h123456A5 : $urandom;
      bytes_b.delete();
      done_b_cnt = 0;
      @(negedge clk);
      start_b = 1'b1; value_b = v;
      @(negedge clk);
      start_b = 1'b0; value_b = $urandom;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (done_b === 1'b1) begin ok = 1'b1; break; end
      end
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL d2_done_timeout v=%h got no done want done", v); end
      repeat (3) @(negedge clk);
      build_exp(v, 2, 1'b0);
      n_cmp++;
      if (bytes_b.size() != exp_q.size()) begin
        n_bad++; $display("FAIL d2_len v=%h got %0d want %0d", v, bytes_b.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_cmp++;
          if (bytes_b[i] !== exp_q[i]) begin n_bad++; $display("FAIL d2_byte v=%h idx=%0d got %h want %h", v, i, bytes_b[i], exp_q[i]); end
        end
      end
      n_cmp++; if (done_b_cnt != 1) begin n_bad++; $display("FAIL d2_done_cnt got %0d want 1", done_b_cnt); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] v;
    int t_rel;
    bit ok;
    v = $urandom;
    clear_a();
    start_pulse_a(v);
    wait_strobes_a(3, 50, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_pre_timeout got %0d strobes want 3", bytes_a.size()); end
    tx_ready = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (bytes_a.size() != 3) begin n_bad++; $display("FAIL stall_no_strobe got %0d strobes want 3", bytes_a.size()); end
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL stall_busy got %b want 1", busy_a); end
    t_rel = cyc;
    tx_ready = 1'b1;
    wait_strobes_a(4, 10, ok);
    n_cmp++;
    if (!ok || times_a[3] != t_rel + 1) begin
      n_bad++; $display("FAIL stall_resume got ok=%0d cycle=%0d want cycle %0d", ok, ok ? times_a[3] : -1, t_rel + 1);
    end
    wait_done_a(200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_done_timeout got no done want done"); end
    build_exp(v, 8, 1'b1);
    n_cmp++;
    if (bytes_a.size() != exp_q.size()) begin
      n_bad++; $display("FAIL stall_len got %0d want %0d", bytes_a.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (bytes_a[i] !== exp_q[i]) begin n_bad++; $display("FAIL stall_byte idx=%0d got %h want %h", i, bytes_a[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_ignore_start();
    bit ok;
    clear_a();
    start_pulse_a(32'h00000001);
    wait_strobes_a(4, 50, ok);
    start_a = 1'b1;
    value_a = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    start_a = 1'b0;
    wait_done_a(200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ign_done_timeout got no done want done"); end
    build_exp(32'h00000001, 8, 1'b1);
    n_cmp++;
    if (bytes_a.size() != exp_q.size()) begin
      n_bad++; $display("FAIL ign_len got %0d want %0d", bytes_a.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (bytes_a[i] !== exp_q[i]) begin n_bad++; $display("FAIL ign_byte idx=%0d got %h want %h", i, bytes_a[i], exp_q[i]); end
      end
    end
    clear_a();
    start_a = 1'b1;
    value_a = 32'hFFFFFFFF;
    @(negedge clk);
    start_a = 1'b0;
    value_a = 32'h0;
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL ign_start_on_done got busy=%b want 1", busy_a); end
    wait_done_a(200, ok);
    build_exp(32'hFFFFFFFF, 8, 1'b1);
    n_cmp++;
    if (!ok || bytes_a.size() != exp_q.size()) begin
      n_bad++; $display("FAIL ign_second_len got ok=%0d len=%0d want 1 %0d", ok, bytes_a.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (bytes_a[i] !== exp_q[i]) begin n_bad++; $display("FAIL ign_second_byte idx=%0d got %h want %h", i, bytes_a[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    bit ok;
    clear_a();
    start_pulse_a($urandom);
    wait_strobes_a(2, 50, ok);
    tx_ovf = 1'b1;
    @(negedge clk);
    tx_ovf = 1'b0;
    @(negedge clk);
    n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL rmid_err_pre got %b want 1", err_a); end
    wait_strobes_a(5, 50, ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", busy_a); end
    n_cmp++; if (txs_a !== 1'b0) begin n_bad++; $display("FAIL rmid_txs got %b want 0", txs_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL rmid_err got %b want 0", err_a); end
    n_cmp++; if (txd_a !== 8'h00) begin n_bad++; $display("FAIL rmid_txd got %h want 00", txd_a); end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    n_cmp++; if (bytes_a.size() != 5 || done_a_cnt != 0) begin n_bad++; $display("FAIL rmid_abort got strobes=%0d done=%0d want 5 0", bytes_a.size(), done_a_cnt); end
    v = $urandom;
    clear_a();
    start_pulse_a(v);
    wait_done_a(200, ok);
    build_exp(v, 8, 1'b1);
    n_cmp++;
    if (!ok || bytes_a.size() != exp_q.size()) begin
      n_bad++; $display("FAIL rmid_fresh_len got ok=%0d len=%0d want 1 %0d", ok, bytes_a.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (bytes_a[i] !== exp_q[i]) begin n_bad++; $display("FAIL rmid_fresh_byte idx=%0d got %h want %h", i, bytes_a[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    bit ok;
    v = $urandom;
    clear_a();
    start_pulse_a(v);
    wait_strobes_a(2, 50, ok);
    tx_ovf = 1'b1;
    @(negedge clk);
    tx_ovf = 1'b0;
    @(negedge clk);
    n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL ovf_err_set got %b want 1", err_a); end
    wait_done_a(200, ok);
    n_cmp++; if (!ok || err_a !== 1'b1) begin n_bad++; $display("FAIL ovf_err_sticky got ok=%0d err=%b want 1 1", ok, err_a); end
    build_exp(v, 8, 1'b1);
    n_cmp++;
    if (bytes_a.size() != exp_q.size()) begin
      n_bad++; $display("FAIL ovf_len got %0d want %0d", bytes_a.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (bytes_a[i] !== exp_q[i]) begin n_bad++; $display("FAIL ovf_byte idx=%0d got %h want %h", i, bytes_a[i], exp_q[i]); end
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL ovf_err_idle got %b want 1", err_a); end
    clear_a();
    start_pulse_a($urandom);
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL ovf_err_clear got %b want 0", err_a); end
    wait_done_a(200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovf_final_timeout got no done want done"); end
  endtask

  task automatic test_integrity();
    n_cmp++; if (consec_a != 0) begin n_bad++; $display("FAIL back_to_back_strobes got %0d want 0", consec_a); end
    n_cmp++; if (hold_a != 0) begin n_bad++; $display("FAIL txd_hold_changes got %0d want 0", hold_a); end
  endtask

  initial begin
    test_reset();
    test_beef();
    test_random_a();
    test_digits2();
    test_stall();
    test_ignore_start();
    test_reset_mid();
    test_overflow();
    test_integrity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no end of test want finish");
    $fatal(1, "watchdog");
  end

endmodule
